// File: rtl/arb_req_pkg.sv
// Shared types for the two-requester arbiter front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arb_req_pkg;
    localparam int NUM_CH = 2;

    // One bit per client channel (request, grant, full, overflow).
    typedef logic [NUM_CH-1:0] ch_vec_t;

    // Index of a client channel, carried on out_src.
    typedef logic [$clog2(NUM_CH)-1:0] ch_idx_t;
endpackage

// File: rtl/req_fifo.sv
// Per-client synchronous FIFO holding words until the arbiter grants them.
// Latency: a word pushed at edge N is counted (and readable at the head) from cycle N+1.
// Backpressure: a push is taken when not full, or when a pop frees a slot in the same cycle.
// Ports: clk/reset; push/wdata write side; pop/rdata read side (rdata = current head);
//        count = stored words, full = count==DEPTH, empty = count==0.
module req_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       pop,
    output logic [DATA_W-1:0]          rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_en;
    logic              rd_en;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // A pop in the same cycle frees the slot the push needs, so full alone
    // does not block the write.
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);

    // Storage carries no reset: stale words are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap DEPTH-1 -> 0 through natural AW-bit overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/arb_req_buffer.sv
// Two client FIFOs turned into level-held requests; a granted head word is popped to one output bus.
// Latency: push -> request 1 cycle; grant -> out_valid 1 cycle; one word per cycle sustained.
// Backpressure: full per channel; a push to a full channel not popping that cycle is dropped (sticky overflow).
// Ports: push/push_data0/push_data1 client writes; full, request to clients/arbiter; grant from arbiter;
//        out_valid/out_src/out_data registered pop output; overflow sticky drop flags; err_grant pulse.
module arb_req_buffer
    import arb_req_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        push,
    input  logic [DATA_W-1:0] push_data0,
    input  logic [DATA_W-1:0] push_data1,
    output logic [1:0]        full,
    output logic [1:0]        request,
    input  logic [1:0]        grant,
    output logic              out_valid,
    output logic              out_src,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        overflow,
    output logic              err_grant
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] head0;
    logic [DATA_W-1:0] head1;
    logic [CW-1:0]     count0;
    logic [CW-1:0]     count1;
    ch_vec_t           empty;
    ch_vec_t           pop;
    ch_vec_t           dropped;

    // Channel 0 wins a double grant; channel 1 simply keeps requesting.
    assign pop[0] = grant[0] & request[0];
    assign pop[1] = grant[1] & request[1] & ~pop[0];

    assign request[0] = (count0 != '0);
    assign request[1] = (count1 != '0);

    assign dropped = push & full & ~pop;

    req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
        .clk   (clk),
        .reset (reset),
        .push  (push[0]),
        .wdata (push_data0),
        .pop   (pop[0]),
        .rdata (head0),
        .count (count0),
        .full  (full[0]),
        .empty (empty[0])
    );

    req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
        .clk   (clk),
        .reset (reset),
        .push  (push[1]),
        .wdata (push_data1),
        .pop   (pop[1]),
        .rdata (head1),
        .count (count1),
        .full  (full[1]),
        .empty (empty[1])
    );

    // out_data/out_src hold the last popped word when nothing pops.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_src   <= 1'b0;
            out_data  <= '0;
            overflow  <= '0;
            err_grant <= 1'b0;
        end else begin
            out_valid <= |pop;
            if (pop[0]) begin
                out_src  <= 1'b0;
                out_data <= head0;
            end else if (pop[1]) begin
                out_src  <= 1'b1;
                out_data <= head1;
            end
            overflow  <= overflow | dropped;
            err_grant <= |(grant & empty);
        end
    end
endmodule

// File: tb/tb_arb_req_buffer.sv
module tb_arb_req_buffer;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] push;
    logic [7:0] push_data0;
    logic [7:0] push_data1;
    logic [1:0] full;
    logic [1:0] request;
    logic [1:0] grant;
    logic       out_valid;
    logic       out_src;
    logic [7:0] out_data;
    logic [1:0] overflow;
    logic       err_grant;

    arb_req_buffer #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data0 (push_data0),
        .push_data1 (push_data1),
        .full       (full),
        .request    (request),
        .grant      (grant),
        .out_valid  (out_valid),
        .out_src    (out_src),
        .out_data   (out_data),
        .overflow   (overflow),
        .err_grant  (err_grant)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: two word queues plus the registered output state.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [1:0] m_ovf;
    logic       m_ov;
    logic       m_src;
    logic [7:0] m_dat;
    logic       m_err;

    // Words the model emitted, as {src, data}, for literal checks per test.
    logic [8:0] got[$];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_req();
        return {q1.size() != 0, q0.size() != 0};
    endfunction

    function automatic logic [1:0] m_full();
        return {q1.size() == DEPTH, q0.size() == DEPTH};
    endfunction

    task automatic model_step(input logic rst, input logic [1:0] p, input logic [7:0] d0,
                              input logic [7:0] d1, input logic [1:0] g);
        int popc;
        int n0;
        int n1;
        logic [1:0] req;
        if (rst) begin
            q0.delete();
            q1.delete();
            m_ovf = 2'b00;
            m_ov  = 1'b0;
            m_src = 1'b0;
            m_dat = 8'h00;
            m_err = 1'b0;
        end else begin
            req   = m_req();
            n0    = q0.size();
            n1    = q1.size();
            m_err = |(g & ~req);
            popc  = -1;
            if (g[0] && req[0])      popc = 0;
            else if (g[1] && req[1]) popc = 1;
            m_ov = (popc >= 0);
            if (popc == 0) begin
                m_src = 1'b0;
                m_dat = q0.pop_front();
            end else if (popc == 1) begin
                m_src = 1'b1;
                m_dat = q1.pop_front();
            end
            if (m_ov) got.push_back({m_src, m_dat});
            if (p[0]) begin
                if (n0 < DEPTH || popc == 0) q0.push_back(d0);
                else m_ovf[0] = 1'b1;
            end
            if (p[1]) begin
                if (n1 < DEPTH || popc == 1) q1.push_back(d1);
                else m_ovf[1] = 1'b1;
            end
        end
    endtask

    // One clock: apply inputs, advance model, sample DUT 1 time unit after the edge.
    task automatic cyc(input logic rst, input logic [1:0] p, input logic [7:0] d0,
                       input logic [7:0] d1, input logic [1:0] g);
        reset      = rst;
        push       = p;
        push_data0 = d0;
        push_data1 = d1;
        grant      = g;
        model_step(rst, p, d0, d1, g);
        @(posedge clk);
        #1;
        chk("request",   int'(request),   int'(m_req()));
        chk("full",      int'(full),      int'(m_full()));
        chk("out_valid", int'(out_valid), int'(m_ov));
        chk("out_src",   int'(out_src),   int'(m_src));
        chk("out_data",  int'(out_data),  int'(m_dat));
        chk("overflow",  int'(overflow),  int'(m_ovf));
        chk("err_grant", int'(err_grant), int'(m_err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 8'h00, 8'h00, 2'b00);
    endtask

    initial begin
        reset = 1'b1; push = 2'b00; grant = 2'b00;
        push_data0 = 8'h00; push_data1 = 8'h00;
        @(negedge clk);

        // Reset then idle.
        for (int i = 0; i < 5; i++) cyc(1'b1, 2'b00, 8'h00, 8'h00, 2'b00);
        idle(3);
        chk("rst_request_lit", int'(request), 0);
        chk("rst_out_lit", int'({out_valid, out_src, out_data, overflow, err_grant}), 0);

        // Single word on ch1.
        got.delete();
        cyc(1'b0, 2'b10, 8'h00, 8'hA5, 2'b00);
        chk("single_req_lit", int'(m_req()), 2);
        cyc(1'b0, 2'b00, 8'h00, 8'h00, 2'b10);
        chk("single_ov_lit", int'(m_ov), 1);
        idle(2);
        chk("single_n_lit", got.size(), 1);
        chk("single_w_lit", int'(got[0]), int'({1'b1, 8'hA5}));
        chk("single_reqoff_lit", int'(m_req()), 0);

        // Fill and overflow on ch0, then drain with one extra grant cycle.
        got.delete();
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b0, 2'b01, 8'(i), 8'h00, 2'b00);
            if (i == 3) chk("fill_notfull_lit", int'(m_full()), 0);
            if (i == 4) chk("fill_full_lit", int'(m_full()), 1);
            if (i == 4) chk("fill_noovf_lit", int'(m_ovf), 0);
        end
        chk("fill_ovf_lit", int'(m_ovf), 1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 2'b00, 8'h00, 8'h00, 2'b01);
        chk("drain_err0_lit", int'(m_err), 0);
        cyc(1'b0, 2'b00, 8'h00, 8'h00, 2'b01);
        chk("drain_err1_lit", int'(m_err), 1);
        idle(1);
        chk("drain_n_lit", got.size(), 4);
        for (int i = 0; i < 4; i++) chk("drain_w_lit", int'(got[i]), i + 1);
        chk("drain_ovf_sticky_lit", int'(m_ovf), 1);

        // Dual grant: ch0 wins, then ch1 served while err flags empty ch0.
        cyc(1'b1, 2'b00, 8'h00, 8'h00, 2'b00);
        got.delete();
        cyc(1'b0, 2'b11, 8'h10, 8'h20, 2'b00);
        cyc(1'b0, 2'b11, 8'h11, 8'h21, 2'b00);
        cyc(1'b0, 2'b00, 8'h00, 8'h00, 2'b11);
        cyc(1'b0, 2'b00, 8'h00, 8'h00, 2'b11);
        chk("dual_req1_lit", int'(m_req()), 2);
        cyc(1'b0, 2'b00, 8'h00, 8'h00, 2'b11);
        chk("dual_err_lit", int'(m_err), 1);
        cyc(1'b0, 2'b00, 8'h00, 8'h00, 2'b10);
        idle(1);
        chk("dual_n_lit", got.size(), 4);
        chk("dual_w0_lit", int'(got[0]), int'({1'b0, 8'h10}));
        chk("dual_w1_lit", int'(got[1]), int'({1'b0, 8'h11}));
        chk("dual_w2_lit", int'(got[2]), int'({1'b1, 8'h20}));
        chk("dual_w3_lit", int'(got[3]), int'({1'b1, 8'h21}));

        // Push and pop in the same cycle while full.
        got.delete();
        for (int i = 0; i < 4; i++) cyc(1'b0, 2'b01, 8'(8'h31 + i), 8'h00, 2'b00);
        cyc(1'b0, 2'b01, 8'h77, 8'h00, 2'b01);
        chk("pp_noovf_lit", int'(m_ovf), 0);
        chk("pp_full_lit", int'(m_full()), 1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 2'b00, 8'h00, 8'h00, 2'b01);
        idle(1);
        chk("pp_n_lit", got.size(), 5);
        chk("pp_last_lit", int'(got[4]), 8'h77);

        // Mid-operation reset discards stored words.
        got.delete();
        for (int i = 0; i < 5; i++) cyc(1'b0, 2'b01, 8'(8'h50 + i), 8'h00, 2'b00);
        chk("mr_ovf_lit", int'(m_ovf), 1);
        cyc(1'b1, 2'b00, 8'h00, 8'h00, 2'b00);
        chk("mr_req_lit", int'(m_req()), 0);
        cyc(1'b0, 2'b00, 8'h00, 8'h00, 2'b01);
        chk("mr_err_lit", int'(m_err), 1);
        idle(2);
        chk("mr_n_lit", got.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
